lcd_rgb_receiver: RTL

LCD_RGB_RECEIVER -- requirements
Module: lcd_rgb_receiver

---
 rtl/lcd_pkg.sv | 29 ++
 rtl/lcd_edge_detect.sv | 29 ++
 rtl/lcd_rgb_receiver.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// ============================================================================
// Module      : lcd_pkg
// Description : Shared LCD receiver constants, FSM encoding and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

  localparam int c_def_width  = 480;
  localparam int c_def_height = 272;
  localparam int c_r_w        = 5;
  localparam int c_g_w        = 6;
  localparam int c_b_w        = 5;
  localparam int c_coord_w    = 10;

  typedef logic [1:0] lcd_state_t;
  localparam lcd_state_t c_st_unlocked = 2'd0;
  localparam lcd_state_t c_st_measure  = 2'd1;
  localparam lcd_state_t c_st_locked   = 2'd2;

  // Coordinate counters stick at full scale instead of wrapping.
  function automatic logic [c_coord_w-1:0] sat_inc10(input logic [c_coord_w-1:0] v);
    return (v == {c_coord_w{1'b1}}) ? v : v + 10'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_edge_detect.sv
// ============================================================================
// Module      : lcd_edge_detect
// Description : Falling-edge detector built on a registered previous value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_fall = r_prev & ~i_sig;

endmodule

`default_nettype wire

// File: rtl/lcd_rgb_receiver.sv
// ============================================================================
// Module      : lcd_rgb_receiver
// Description : Parallel RGB565 LCD receiver: coordinate recovery, geometry
//               measurement, lock tracking. LCD_RGB_RX_CHECKSUM_EN adds a
//               per-frame pixel checksum on out_checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_rgb_receiver
  import lcd_pkg::*;
#(
  parameter int EXP_WIDTH   = c_def_width,
  parameter int EXP_HEIGHT  = c_def_height,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_en,
  input  logic                 in_hsync,
  input  logic                 in_vsync,
  input  logic [c_r_w-1:0]     in_r,
  input  logic [c_g_w-1:0]     in_g,
  input  logic [c_b_w-1:0]     in_b,
  output logic                 out_pix_valid,
  output logic [c_coord_w-1:0] out_pixelx,
  output logic [c_coord_w-1:0] out_pixely,
  output logic [c_r_w-1:0]     out_r,
  output logic [c_g_w-1:0]     out_g,
  output logic [c_b_w-1:0]     out_b,
  output logic                 out_sof,
  output logic                 out_locked,
  output logic                 out_err,
  output logic [c_coord_w-1:0] out_width,
  output logic [c_coord_w-1:0] out_height,
  output logic [7:0]           out_err_count,
  output logic [15:0]          out_checksum
);

  localparam logic [c_coord_w-1:0] c_exp_w  = c_coord_w'(EXP_WIDTH);
  localparam logic [c_coord_w-1:0] c_exp_h  = c_coord_w'(EXP_HEIGHT);
  localparam logic [7:0]           c_lock_n = 8'(LOCK_FRAMES);

  logic             r_en, r_hs, r_vs;
  logic [c_r_w-1:0] r_r;
  logic [c_g_w-1:0] r_g;
  logic [c_b_w-1:0] r_b;
  logic             w_en_fall, w_vs_fall;
  logic             w_unused_hsync;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_en <= 1'b0;
      r_hs <= 1'b0;
      r_vs <= 1'b0;
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
    end else begin
      r_en <= in_en;
      r_hs <= in_hsync;
      r_vs <= in_vsync;
      r_r  <= in_r;
      r_g  <= in_g;
      r_b  <= in_b;
    end
  end

  // Line timing comes from data-enable alone; hsync is captured but not needed.
  assign w_unused_hsync = r_hs;

  lcd_edge_detect u_en_edge (
    .clk    (in_clk),
    .rst_n  (in_rst_n),
    .i_sig  (r_en),
    .o_fall (w_en_fall)
  );

  lcd_edge_detect u_vs_edge (
    .clk    (in_clk),
    .rst_n  (in_rst_n),
    .i_sig  (r_vs),
    .o_fall (w_vs_fall)
  );

  logic [c_coord_w-1:0] r_x, r_y, r_line_w;
  logic                 r_bad, r_sof_arm;
  logic [c_coord_w-1:0] w_width_now, w_height_now;
  logic                 w_line_bad, w_frame_bad, w_frame_ok;
  lcd_state_t           r_state, w_state_next;
  logic [7:0]           r_good, w_good_next;
  logic                 w_err_evt;

  // A line ending in the same cycle as the frame must be folded into the frame.
  assign w_line_bad   = (r_x != c_exp_w);
  assign w_width_now  = w_en_fall ? r_x : r_line_w;
  assign w_height_now = w_en_fall ? sat_inc10(r_y) : r_y;
  assign w_frame_bad  = r_bad | (w_en_fall & w_line_bad);
  assign w_frame_ok   = !w_frame_bad && (w_height_now == c_exp_h);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_line_w      <= '0;
      r_bad         <= 1'b0;
      r_sof_arm     <= 1'b0;
      out_pix_valid <= 1'b0;
      out_pixelx    <= '0;
      out_pixely    <= '0;
      out_r         <= '0;
      out_g         <= '0;
      out_b         <= '0;
      out_sof       <= 1'b0;
      out_err       <= 1'b0;
      out_width     <= '0;
      out_height    <= '0;
      out_err_count <= '0;
    end else begin
      out_pix_valid <= r_en;
      out_sof       <= r_en & (r_sof_arm | w_vs_fall);
      out_err       <= w_err_evt;
      if (r_en) begin
        out_pixelx <= r_x;
        out_pixely <= r_y;
        out_r      <= r_r;
        out_g      <= r_g;
        out_b      <= r_b;
        r_x        <= sat_inc10(r_x);
      end else if (w_en_fall) begin
        r_x <= '0;
      end
      if (w_en_fall) begin
        r_line_w <= r_x;
      end
      if (w_vs_fall) begin
        r_y        <= '0;
        r_bad      <= 1'b0;
        out_height <= w_height_now;
        out_width  <= w_width_now;
      end else if (w_en_fall) begin
        r_y <= sat_inc10(r_y);
        if (w_line_bad) begin
          r_bad <= 1'b1;
        end
      end
      if (r_en) begin
        r_sof_arm <= 1'b0;
      end else if (w_vs_fall) begin
        r_sof_arm <= 1'b1;
      end
      if (w_err_evt && (out_err_count != 8'hFF)) begin
        out_err_count <= out_err_count + 8'd1;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= c_st_unlocked;
      r_good  <= '0;
    end else begin
      r_state <= w_state_next;
      r_good  <= w_good_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good;
    if (w_vs_fall) begin
      case (r_state)
        c_st_unlocked: begin
          w_state_next = c_st_measure;
          w_good_next  = '0;
        end
        c_st_measure: begin
          if (!w_frame_ok) begin
            w_good_next = '0;
          end else if ((r_good + 8'd1) >= c_lock_n) begin
            w_state_next = c_st_locked;
            w_good_next  = '0;
          end else begin
            w_good_next = r_good + 8'd1;
          end
        end
        c_st_locked: begin
          if (!w_frame_ok) begin
            w_state_next = c_st_unlocked;
          end
        end
        default: begin
          w_state_next = c_st_unlocked;
          w_good_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    out_locked = (r_state == c_st_locked);
    w_err_evt  = (r_state == c_st_locked) && w_vs_fall && !w_frame_ok;
  end

`ifdef LCD_RGB_RX_CHECKSUM_EN
  logic [15:0] r_csum_acc;
  logic [15:0] w_csum_now;

  assign w_csum_now = r_csum_acc + (r_en ? {r_r, r_g, r_b} : 16'd0);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_csum_acc   <= '0;
      out_checksum <= '0;
    end else if (w_vs_fall) begin
      r_csum_acc   <= '0;
      out_checksum <= w_csum_now;
    end else begin
      r_csum_acc <= w_csum_now;
    end
  end
`else
  assign out_checksum = 16'd0;
`endif

endmodule

`default_nettype wire
